// File: rtl/sap_ab_regs.sv
// SAP-1 accumulator (A), B register and carry/zero flags register.
// A and B load from the shared bus, and A can drive the bus back.
// Optional macro SAP_ACC_SHIFT_EN enables the accumulator rotate-through-carry
// and clear operations selected by acc_op. When the macro is not defined,
// acc_op is accepted but ignored.
module sap_ab_regs (
  input  logic       CLK,
  input  logic       CLR,
  inout  wire  [7:0] DATA,
  input  logic       la,
  input  logic       ea,
  input  logic       lb,
  input  logic       lf,
  input  logic [1:0] acc_op,
  input  logic       alu_c,
  input  logic       alu_z,
  output logic [7:0] a_reg_data,
  output logic [7:0] b_reg_data,
  output logic       flag_c,
  output logic       flag_z
);

  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic       c_reg;
  logic       z_reg;

  logic [7:0] a_next;
  logic [7:0] b_next;
  logic       c_next;
  logic       z_next;

  // The bus is released while CLR is high so a reset never fights another driver.
  assign DATA = (ea && !CLR) ? a_reg : 8'bz;

  assign a_reg_data = a_reg;
  assign b_reg_data = b_reg;
  assign flag_c     = c_reg;
  assign flag_z     = z_reg;

`ifdef SAP_ACC_SHIFT_EN
  // Next-state logic: a bus load beats any accumulator op, and a rotate owns the flags.
  always_comb begin
    a_next = a_reg;
    b_next = b_reg;
    c_next = c_reg;
    z_next = z_reg;

    if (lb)
      b_next = DATA;

    if (la) begin
      a_next = DATA;
      if (lf) begin
        c_next = alu_c;
        z_next = alu_z;
      end
    end else begin
      case (acc_op)
        2'b01: begin
          a_next = {a_reg[6:0], c_reg};
          c_next = a_reg[7];
          z_next = ({a_reg[6:0], c_reg} == 8'h00);
        end
        2'b10: begin
          a_next = {c_reg, a_reg[7:1]};
          c_next = a_reg[0];
          z_next = ({c_reg, a_reg[7:1]} == 8'h00);
        end
        2'b11: begin
          a_next = 8'h00;
          if (lf) begin
            c_next = alu_c;
            z_next = alu_z;
          end else begin
            z_next = 1'b1;
          end
        end
        default: begin
          if (lf) begin
            c_next = alu_c;
            z_next = alu_z;
          end
        end
      endcase
    end
  end
`else
  logic unused_acc_op;
  assign unused_acc_op = ^acc_op;

  // Next-state logic: A changes only by a bus load, and the flags change only by lf.
  always_comb begin
    a_next = a_reg;
    b_next = b_reg;
    c_next = c_reg;
    z_next = z_reg;

    if (la)
      a_next = DATA;
    if (lb)
      b_next = DATA;
    if (lf) begin
      c_next = alu_c;
      z_next = alu_z;
    end
  end
`endif

  // State registers: reset asynchronously, then update on each rising edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      a_reg <= 8'h00;
      b_reg <= 8'h00;
      c_reg <= 1'b0;
      z_reg <= 1'b0;
    end else begin
      a_reg <= a_next;
      b_reg <= b_next;
      c_reg <= c_next;
      z_reg <= z_next;
    end
  end

endmodule

// File: tb/tb_sap_ab_regs.sv
// Self-checking bench for sap_ab_regs: a table of directed single-edge vectors
// followed by hand-written sequences for reset, bus drive and accumulator ops.
module tb_sap_ab_regs;

  logic       CLK;
  logic       CLR;
  wire  [7:0] DATA;
  logic       la;
  logic       ea;
  logic       lb;
  logic       lf;
  logic [1:0] acc_op;
  logic       alu_c;
  logic       alu_z;
  logic [7:0] a_reg_data;
  logic [7:0] b_reg_data;
  logic       flag_c;
  logic       flag_z;

  logic       tb_drive_en;
  logic [7:0] tb_bus;

  int checks_total;
  int checks_passed;

  typedef struct {
    logic       la;
    logic       lb;
    logic       lf;
    logic       ea;
    logic [1:0] acc_op;
    logic       alu_c;
    logic       alu_z;
    logic       drive;
    logic [7:0] bus;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t vecs[10];

  assign DATA = tb_drive_en ? tb_bus : 8'bz;

  sap_ab_regs dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .DATA       (DATA),
    .la         (la),
    .ea         (ea),
    .lb         (lb),
    .lf         (lf),
    .acc_op     (acc_op),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .a_reg_data (a_reg_data),
    .b_reg_data (b_reg_data),
    .flag_c     (flag_c),
    .flag_z     (flag_z)
  );

  // Free-running clock with a 10 time-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkState(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c, input logic z);
    checkOutput({tag, " A"}, a_reg_data, a);
    checkOutput({tag, " B"}, b_reg_data, b);
    checkOutput({tag, " C"}, {7'd0, flag_c}, {7'd0, c});
    checkOutput({tag, " Z"}, {7'd0, flag_z}, {7'd0, z});
  endtask

  // Drives one set of controls from a negedge, then returns 1 unit after the rising edge.
  task automatic applyStimulus(input logic l_a, input logic l_b, input logic l_f, input logic e_a,
                               input logic [1:0] op, input logic ac, input logic az,
                               input logic drv, input logic [7:0] bus);
    @(negedge CLK);
    la          = l_a;
    lb          = l_b;
    lf          = l_f;
    ea          = e_a;
    acc_op      = op;
    alu_c       = ac;
    alu_z       = az;
    tb_drive_en = drv;
    tb_bus      = bus;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    @(negedge CLK);
    la          = 1'b0;
    lb          = 1'b0;
    lf          = 1'b0;
    ea          = 1'b0;
    acc_op      = 2'b00;
    alu_c       = 1'b0;
    alu_z       = 1'b0;
    tb_drive_en = 1'b0;
    tb_bus      = 8'h00;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    CLR           = 1'b1;
    la            = 1'b0;
    lb            = 1'b0;
    lf            = 1'b0;
    ea            = 1'b0;
    acc_op        = 2'b00;
    alu_c         = 1'b0;
    alu_z         = 1'b0;
    tb_drive_en   = 1'b0;
    tb_bus        = 8'h00;

    //            la   lb   lf   ea   op     c    z    drv  bus    A      B      C    Z
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,8'h3C, 8'h3C,8'h00,1'b0,1'b0};
    vecs[1] = '{1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,8'h11, 8'h3C,8'h11,1'b0,1'b0};
    vecs[2] = '{1'b0,1'b0,1'b1,1'b0,2'b00,1'b1,1'b0,1'b0,8'h00, 8'h3C,8'h11,1'b1,1'b0};
    vecs[3] = '{1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b1,1'b1,8'hFF, 8'hFF,8'h11,1'b0,1'b1};
    vecs[4] = '{1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,8'h01, 8'hFF,8'h01,1'b0,1'b1};
    vecs[5] = '{1'b0,1'b0,1'b1,1'b0,2'b00,1'b1,1'b1,1'b0,8'h00, 8'hFF,8'h01,1'b1,1'b1};
    vecs[6] = '{1'b0,1'b1,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,8'h00, 8'hFF,8'hFF,1'b1,1'b1};
    vecs[7] = '{1'b1,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,8'h00, 8'hFF,8'hFF,1'b1,1'b1};
    vecs[8] = '{1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,8'h00, 8'hFF,8'hFF,1'b1,1'b1};
    vecs[9] = '{1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,8'h81, 8'h81,8'h81,1'b1,1'b1};

    // Reset held across several edges: every register reads zero.
    repeat (3) @(posedge CLK);
    #1;
    checkState("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    CLR = 1'b0;

    // Table-driven single-edge vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].la, vecs[i].lb, vecs[i].lf, vecs[i].ea, vecs[i].acc_op,
                    vecs[i].alu_c, vecs[i].alu_z, vecs[i].drive, vecs[i].bus);
      checkState($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c, vecs[i].exp_z);
    end

    // Bus drive: A appears on DATA combinationally when ea is high.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h3C);
    idle();
    ea = 1'b1;
    #1;
    checkOutput("drive ea=1", DATA, 8'h3C);
    ea          = 1'b0;
    tb_drive_en = 1'b1;
    tb_bus      = 8'h11;
    #1;
    checkOutput("release ea=0", DATA, 8'h11);
    tb_drive_en = 1'b0;

    // Mid-cycle CLR clears everything at once and discards a pending load.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h5A);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h5A);
    checkState("preclr", 8'h5A, 8'h5A, 1'b1, 1'b1);
    idle();
    ea = 1'b1;
    #2;
    CLR = 1'b1;
    #1;
    checkState("midclr", 8'h00, 8'h00, 1'b0, 1'b0);
    la          = 1'b1;
    tb_drive_en = 1'b1;
    tb_bus      = 8'h99;
    @(posedge CLK);
    #1;
    checkOutput("clr held load", a_reg_data, 8'h00);
    @(negedge CLK);
    CLR = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("load after clr", a_reg_data, 8'h99);
    idle();

`ifdef SAP_ACC_SHIFT_EN
    // Rotate left then right through carry.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h81);
    checkState("rot setup", 8'h81, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
    checkState("rol", 8'h02, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00);
    checkState("ror", 8'h81, 8'h00, 1'b0, 1'b0);
    // Rotate beats lf for the flags.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00);
    checkState("ror lf", 8'h40, 8'h00, 1'b1, 1'b0);
    // Load beats rotate; lf then supplies the flags.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00);
    checkState("la prio", 8'h00, 8'h00, 1'b1, 1'b0);
    // Rotate producing zero sets Z.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h80);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
    checkState("rol zero", 8'h00, 8'h00, 1'b1, 1'b1);
    // Clear keeps C and sets Z; with lf the ALU flags win.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00);
    checkState("clr a", 8'h00, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00);
    checkState("clr a lf", 8'h00, 8'h00, 1'b0, 1'b0);
`else
    // Accumulator ops are ignored: A and flags hold.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h77);
    checkState("op setup", 8'h77, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00);
    checkState("op clr off", 8'h77, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
    checkState("op rol off", 8'h77, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00);
    checkState("op ror off", 8'h77, 8'h00, 1'b1, 1'b0);
`endif
    idle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
